// File: rtl/stage_4_pkg.sv
// stage_4_pkg -- constants and helpers shared by the memory stage.
//   * FSM state encodings (IDLE / WAIT)
//   * RV32 opcodes that the stage decodes
//   * LOAD / STORE func_3 codes
//   * SIGN_EXTEND macro used by the load aligner
//   * helpers for func_3 legality, alignment and store lane formatting
`ifndef STAGE_4_SIGN_EXTEND_DEFINED
`define STAGE_4_SIGN_EXTEND_DEFINED
// Sign-extend a w-bit vector val to 32 bits; val must be exactly w bits wide.
`define SIGN_EXTEND(val, w) {{(32-(w)){val[(w)-1]}}, val}
`endif

package stage_4_pkg;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Opcodes
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // LOAD func_3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // STORE func_3 codes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Opcodes whose result lands in the register file.
  function automatic logic opcode_writes_rd(input logic [6:0] opcode);
    logic res;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_JAL, OPC_JALR,
      OPC_LUI, OPC_AUIPC, OPC_LOAD: res = 1'b1;
      default:                      res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic load_f3_legal(input logic [2:0] f3);
    logic res;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    logic res;
    case (f3)
      F3_SB, F3_SH, F3_SW: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  // f3[1:0] encodes access size for both loads and stores (00 byte, 01 half, 10 word).
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic res;
    case (f3[1:0])
      2'b01:   res = lane[0];
      2'b10:   res = (lane != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Store data replicated across every lane the access could hit.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs_2);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = {4{rs_2[7:0]}};
      2'b01:   res = {2{rs_2[15:0]}};
      default: res = rs_2;
    endcase
    return res;
  endfunction

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] res;
    case (f3[1:0])
      2'b00:   res = 4'b0001 << lane;
      2'b01:   res = lane[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stage_4_if.sv
// stage_4_if -- data-memory bus between stage_4 and the memory.
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : request, driven by master
//   mem_rdata/mem_ack                        : response, driven by slave
interface stage_4_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stage_4_mem_align.sv
// stage_4_mem_align -- combinational load-data aligner.
//   rdata  : raw 32-bit word from memory
//   lane   : addr[1:0] of the load
//   func_3 : load width / signedness
//   data   : lane-selected, sign- or zero-extended result
module stage_4_mem_align
  import stage_4_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  func_3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte / halfword and extend it.
  always_comb begin
    byte_s = rdata[7:0];
    half_s = rdata[15:0];
    data   = rdata;
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (func_3)
      F3_LB:   data = `SIGN_EXTEND(byte_s, 8);
      F3_LH:   data = `SIGN_EXTEND(half_s, 16);
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_s};
      F3_LHU:  data = {16'd0, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_4.sv
// stage_4 -- memory stage of the pipeline.
//   clk, rst       : clock, synchronous active-high reset
//   i_*            : execute-stage result (held by upstream while stall=1)
//   stall          : high while a memory access is outstanding
//   mem            : data-memory bus (master side)
//   valid, wb_en   : result valid, register-file write enable
//   rd_num,wb_data : writeback destination and value
//   mem_fault      : result came from a misaligned or illegal access
// ALU results retire one cycle after accept. Legal memory accesses go to
// WAIT and hold the request until mem_ack; faulting accesses retire at once
// with mem_fault and no request.
module stage_4
  import stage_4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        stall,
  stage_4_if.master   mem,
  output logic        valid,
  output logic        wb_en,
  output logic [4:0]  rd_num,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  logic [0:0]  state_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_be_r;
  logic        valid_r;
  logic        wb_en_r;
  logic [4:0]  rd_num_r;
  logic [31:0] wb_data_r;
  logic        mem_fault_r;

  // Context of the outstanding access, needed when the ack returns.
  logic [4:0]  pend_rd_r;
  logic        pend_wb_en_r;
  logic [2:0]  pend_func3_r;
  logic [1:0]  pend_lane_r;

  logic        accept_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        access_ok_s;
  logic        wb_en_s;
  logic [31:0] load_data_s;

  // Decode the incoming instruction.
  always_comb begin
    accept_s    = i_valid && (state_r == ST_IDLE);
    is_load_s   = (i_opcode == OPC_LOAD);
    is_store_s  = (i_opcode == OPC_STORE);
    wb_en_s     = (i_rd_num != 5'd0) && opcode_writes_rd(i_opcode);
    access_ok_s = 1'b0;
    if (is_load_s) begin
      access_ok_s = load_f3_legal(i_func_3) && !access_misaligned(i_func_3, i_alu_out[1:0]);
    end else if (is_store_s) begin
      access_ok_s = store_f3_legal(i_func_3) && !access_misaligned(i_func_3, i_alu_out[1:0]);
    end else begin
      access_ok_s = 1'b0;
    end
  end

  stage_4_mem_align u_mem_align (
    .rdata  (mem.mem_rdata),
    .lane   (pend_lane_r),
    .func_3 (pend_func3_r),
    .data   (load_data_s)
  );

  // FSM, memory request registers and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      mem_be_r     <= 4'd0;
      valid_r      <= 1'b0;
      wb_en_r      <= 1'b0;
      rd_num_r     <= 5'd0;
      wb_data_r    <= 32'd0;
      mem_fault_r  <= 1'b0;
      pend_rd_r    <= 5'd0;
      pend_wb_en_r <= 1'b0;
      pend_func3_r <= 3'd0;
      pend_lane_r  <= 2'd0;
    end else begin
      // Results are single-cycle pulses unless re-asserted below.
      valid_r     <= 1'b0;
      wb_en_r     <= 1'b0;
      mem_fault_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!i_op_type) begin
              valid_r   <= 1'b1;
              wb_en_r   <= wb_en_s;
              rd_num_r  <= i_rd_num;
              wb_data_r <= i_alu_out;
            end else if (access_ok_s) begin
              state_r      <= ST_WAIT;
              mem_req_r    <= 1'b1;
              mem_we_r     <= is_store_s;
              mem_addr_r   <= {i_alu_out[31:2], 2'b00};
              mem_wdata_r  <= is_store_s ? store_wdata(i_func_3, i_rs_2) : 32'd0;
              mem_be_r     <= access_be(i_func_3, i_alu_out[1:0]);
              pend_rd_r    <= i_rd_num;
              pend_wb_en_r <= wb_en_s;
              pend_func3_r <= i_func_3;
              pend_lane_r  <= i_alu_out[1:0];
            end else begin
              valid_r     <= 1'b1;
              mem_fault_r <= 1'b1;
              rd_num_r    <= i_rd_num;
              wb_data_r   <= 32'd0;
            end
          end
        end
        ST_WAIT: begin
          // Request fields stay frozen until the ack is sampled.
          if (mem.mem_ack) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            valid_r   <= 1'b1;
            wb_en_r   <= pend_wb_en_r;
            rd_num_r  <= pend_rd_r;
            wb_data_r <= mem_we_r ? 32'd0 : load_data_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign stall         = (state_r == ST_WAIT);
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign mem.mem_be    = mem_be_r;
  assign valid         = valid_r;
  assign wb_en         = wb_en_r;
  assign rd_num        = rd_num_r;
  assign wb_data       = wb_data_r;
  assign mem_fault     = mem_fault_r;

endmodule

// File: doc/stage_4.md
STAGE_4 -- requirements
Module: stage_4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_valid  input  1  execute-stage result valid.
REQ-005 i_alu_out  input  32  ALU result, or effective address when i_op_type=1.
REQ-006 i_rs_2  input  32  store data.
REQ-007 i_rd_num  input  5  destination register.
REQ-008 i_opcode  input  7  instruction opcode.
REQ-009 i_func_3  input  3  access width and signedness.
REQ-010 i_op_type  input  1  0 = ALU pass-through, 1 = memory access.
REQ-011 stall  output  1  upstream holds its inputs while high.
REQ-012 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-013 mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-017 mem_ack  input  1  one-cycle request completion.
REQ-018 valid, wb_en  output  1 each  result valid; register-file write enable.
REQ-019 rd_num  output  5  destination register to writeback.
REQ-020 wb_data  output  32  writeback value.
REQ-021 mem_fault  output  1  misaligned access or illegal func_3.

Function
REQ-022 Accept condition: i_valid=1 and stall=0 at a rising edge.
REQ-023 FSM states: IDLE, WAIT.
- stall SHALL equal (state==WAIT).
REQ-024 Accepted op_type=0 instruction:
- Next cycle: valid=1, wb_data=i_alu_out, rd_num=i_rd_num, mem_req=0.
- Latency: 1 cycle.
REQ-025 wb_en SHALL be 1 only when rd_num!=0 and the opcode is one of OP, OPIMM, JAL, JALR, LUI, AUIPC, LOAD; it SHALL be 0 for STORE and all other opcodes.
REQ-026 Legal func_3 values:
- LOAD: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- STORE: SB=000, SH=001, SW=010.
- Any other value is illegal.
REQ-027 Misalignment rules:
- Halfword access is misaligned when addr[0]=1.
- Word access is misaligned when addr[1:0]!=0.
REQ-028 Accepted op_type=1 with a legal, aligned access:
- Next cycle: state=WAIT and mem_req=1.
- mem_we=1 for STORE, 0 for LOAD.
- valid=0.
REQ-029 In WAIT, mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be held stable until mem_ack=1 is sampled.
REQ-030 On the cycle after mem_ack is sampled:
- state=IDLE, mem_req=0, stall=0.
- valid=1 for exactly one cycle.
- Minimum memory latency: 2 cycles (ack in the first request cycle).
REQ-031 Store data and byte enables:
- SB: wdata={4{rs_2[7:0]}}, be=4'b0001<<addr[1:0].
- SH: wdata={2{rs_2[15:0]}}, be=addr[1]?1100:0011.
- SW: wdata=rs_2, be=1111.
REQ-032 Load data: select the byte/halfword lane by addr[1:0]/addr[1].
- LB/LH: sign-extend to 32 bits.
- LBU/LHU: zero-extend.
- LW: pass through.
REQ-033 An illegal or misaligned access SHALL issue no memory request; the next cycle it SHALL give valid=1, mem_fault=1, wb_en=0.
REQ-034 mem_fault SHALL be 0 for every other result.
REQ-035 mem_ack received while in IDLE SHALL be ignored.
REQ-036 valid SHALL be 0 in any cycle following no accept and no ack.

Reset
REQ-037 While rst=1, state=IDLE and stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, valid, wb_en, rd_num, wb_data and mem_fault SHALL all be 0 at the next edge.
REQ-038 Reset during WAIT SHALL abandon the transaction:
- mem_req=0 on the cycle after the reset edge.
- A late mem_ack SHALL be ignored.
REQ-039 Reset SHALL take priority over accept and mem_ack in the same cycle.

Structure
REQ-040 The LOAD/STORE func_3 codes, the FSM state encodings and the opcodes SHALL live in the shared constants include.
REQ-041 Sign extension SHALL use the shared SIGN_EXTEND utility macro.
REQ-042 Lane selection and extension SHALL be a combinational sub-module, mem_align, instantiated once for loads.

Verification
REQ-043 ADDI result: i_alu_out=0x0000_0010, rd=5, op_type=0 -> next cycle valid=1, wb_en=1, wb_data=0x10, mem_req=0.
REQ-044 LB: addr=0x103, mem_rdata=0x80_00_00_00, ack 3 cycles after req -> stall held 3 cycles, wb_data=0xFFFF_FF80, rd written.
REQ-045 SH: addr=0x202, rs_2=0x1234_ABCD, ack in first request cycle -> mem_addr=0x200, be=1100, wdata=0xABCD_ABCD, wb_en=0, total latency 2 cycles.
REQ-046 LW: addr=0x101 -> no mem_req, next cycle valid=1, mem_fault=1, wb_en=0.
REQ-047 rst=1 in the second WAIT cycle, then mem_ack=1 -> mem_req=0 and valid=0 after the reset edge; the ack produces no valid.
REQ-048 Back-to-back: LW accepted, then ADD presented and held during stall -> ADD accepted the cycle after the load result; results appear in order.
